// File: rtl/barret_367_pkg.sv
// Shared constants for the mod-367 reducer and its round-robin front end.
package barret_367_pkg;

    localparam int Q           = 367;
    localparam int IN_W        = 17;
    localparam int OUT_W       = 9;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = 2;

    // Barrett constants: BM = floor(2^BK / Q); the quotient estimate is low by at most one.
    localparam int BK = 26;
    localparam int BM = 182857;
    localparam int BM_W = 18;

endpackage

// File: rtl/barret_for_367.sv
// Combinational Barrett reduction of a 17-bit operand modulo 367.
module barret_for_367
    import barret_367_pkg::*;
(
    input  logic [IN_W-1:0]  din_a,
    output logic [OUT_W-1:0] dout_r
);

    localparam int PROD_W = IN_W + BM_W;

    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  q_est;
    logic [IN_W-1:0]   q_mul;
    logic [IN_W-1:0]   rem;
    logic [IN_W-1:0]   rem_adj;

    always_comb begin
        prod    = PROD_W'(din_a) * PROD_W'(BM);
        q_est   = OUT_W'(prod >> BK);
        q_mul   = IN_W'(q_est) * IN_W'(Q);
        // rem lies in [0, 2*Q) because q_est undershoots by at most one
        rem     = din_a - q_mul;
        rem_adj = rem;
        if (rem >= IN_W'(Q)) begin
            rem_adj = rem - IN_W'(Q);
        end
        dout_r  = OUT_W'(rem_adj);
    end

endmodule

// File: rtl/barret_367_arbiter.sv
// Round-robin arbiter feeding a two-stage mod-367 pipeline (S1 operand, S2 result).
// Handshake: a beat moves on a rising edge where valid and ready are both high; ready never waits on data.
module barret_367_arbiter
    import barret_367_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      in_valid,
    input  logic [NUM_REQ*IN_W-1:0] in_data,
    output logic [NUM_REQ-1:0]      in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id
);

    logic              s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]   s1_data_q, s1_data_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]  s2_data_q, s2_data_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              adv;
    logic              accept_ok;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic [IN_W-1:0]   grant_data;
    logic [OUT_W-1:0]  red_r;

    assign adv       = !s2_valid_q || out_ready;
    assign accept_ok = !s1_valid_q || adv;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && in_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_data = in_data[IN_W*i +: IN_W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_found && accept_ok && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    barret_for_367 u_reduce (
        .din_a  (s1_data_q),
        .dout_r (red_r)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        rr_ptr_d   = rr_ptr_q;

        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = red_r;
                s2_id_d   = s1_id_q;
            end
        end

        // S1 either loads the granted operand or drains empty once its content has moved on.
        if (accept_ok) begin
            s1_valid_d = grant_found;
            if (grant_found) begin
                s1_data_d = grant_data;
                s1_id_d   = grant_idx;
                if (grant_idx == ID_W'(NUM_REQ-1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;

endmodule

// File: tb/tb_barret_367_arbiter.sv
// Bench for barret_367_arbiter: a depth-2 in-order queue model with one-edge minimum latency,
// round-robin grant computed from an integer pointer, directed cases and randomized traffic.
module tb_barret_367_arbiter;

    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*17-1:0]  in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [8:0]       out_data;
    logic [1:0]       out_id;

    barret_367_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int id;
        int acc;
    } ent_t;

    ent_t mq[$];
    int   m_rr;
    int   m_cyc;
    bit   req_v[N];
    int   req_d[N];
    int   log_d[$];
    int   log_id[$];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            in_valid[i]         = req_v[i];
            in_data[17*i +: 17] = 17'(req_d[i]);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_rr = 0;
        for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    endtask

    // Called at a falling edge: checks this cycle's outputs, then advances the model over the next rising edge.
    task automatic tick();
        int  g;
        bit  acc;
        bit  vis;
        int  exp_r;
        apply();
        #1;
        g     = model_grant();
        acc   = (g >= 0) && ((mq.size() < 2) || out_ready);
        exp_r = acc ? (1 << g) : 0;
        vis   = (mq.size() > 0) && (mq[0].acc < m_cyc);
        chk("in_ready", 32'(in_ready), 32'(exp_r));
        chk("out_valid", 32'(out_valid), 32'(vis));
        if (vis) begin
            chk("out_data", 32'(out_data), 32'(mq[0].d % 367));
            chk("out_id", 32'(out_id), 32'(mq[0].id));
            if (out_ready) begin
                log_d.push_back(int'(out_data));
                log_id.push_back(int'(out_id));
            end
        end
        @(posedge clk);
        m_cyc++;
        if (vis && out_ready) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{req_d[g], g, m_cyc});
            req_v[g] = 1'b0;
            m_rr     = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) req_v[i] = 1'b1;
        apply();
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        model_clear();
        apply();
        @(negedge clk);
        rst = 1'b0;
        log_d.delete();
        log_id.delete();
    endtask

    // Asynchronous assertion between clock edges, held across one rising edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        apply();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int sent;
        int ops[5];
        int exp_b[5];
        n_chk  = 0;
        n_fail = 0;
        m_cyc  = 0;
        for (int i = 0; i < N; i++) req_d[i] = 0;
        in_valid = '0;
        in_data  = '0;

        // Single request from requester 2.
        do_reset();
        out_ready = 1'b1;
        req_v[2] = 1'b1;
        req_d[2] = 1000;
        apply();
        #1;
        chk("single_in_ready", 32'(in_ready), 32'b0100);
        tick();
        tick();
        apply();
        #1;
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'd266);
        chk("single_out_id", 32'(out_id), 32'd2);
        repeat (3) tick();

        // Boundary operands, then a sweep 367..1100, all from requester 0.
        do_reset();
        out_ready = 1'b1;
        ops   = '{0, 366, 367, 131071, 134};
        exp_b = '{0, 366, 0, 52, 134};
        for (int v = 0; v < 5 + 734; v++) begin
            req_v[0] = 1'b1;
            req_d[0] = (v < 5) ? ops[v] : 367 + (v - 5);
            for (int t = 0; t < 10 && req_v[0]; t++) tick();
            if (req_v[0]) chk("bound_accept_timeout", 32'd0, 32'd1);
        end
        repeat (4) tick();
        chk("bound_count", 32'(log_d.size()), 32'd739);
        if (log_d.size() == 739) begin
            for (int k = 0; k < 5; k++) chk("bound_value", 32'(log_d[k]), 32'(exp_b[k]));
            chk("bound_last", 32'(log_d[738]), 32'd366);
        end

        // Fairness with every requester permanently valid.
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && log_d.size() < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                req_v[i] = 1'b1;
                req_d[i] = 10 * (i + 1);
            end
            tick();
        end
        chk("fair_count_ok", 32'(log_d.size() >= 6), 32'd1);
        if (log_d.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("fair_id", 32'(log_id[k]), 32'(k % 4));
                chk("fair_data", 32'(log_d[k]), 32'(10 * ((k % 4) + 1)));
            end
        end
        for (int i = 0; i < N; i++) req_v[i] = 1'b0;
        repeat (4) tick();

        // Backpressure: five operands from requester 1 against a 4-cycle stall.
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        for (int t = 0; t < 2; t++) begin
            if (!req_v[1] && sent < 5) begin req_v[1] = 1'b1; req_d[1] = 500 + sent; sent++; end
            tick();
        end
        for (int t = 0; t < 4; t++) begin
            if (!req_v[1] && sent < 5) begin req_v[1] = 1'b1; req_d[1] = 500 + sent; sent++; end
            apply();
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'd133);
            chk("bp_out_id", 32'(out_id), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 30 && (sent < 5 || req_v[1] || mq.size() > 0); t++) begin
            if (!req_v[1] && sent < 5) begin req_v[1] = 1'b1; req_d[1] = 500 + sent; sent++; end
            tick();
        end
        chk("bp_count", 32'(log_d.size()), 32'd5);
        if (log_d.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("bp_order", 32'(log_d[k]), 32'(133 + k));
        end

        // Reset with both stages full, pointer moved off zero.
        do_reset();
        out_ready = 1'b0;
        req_v[2] = 1'b1; req_d[2] = 700;
        tick();
        req_v[2] = 1'b1; req_d[2] = 701;
        tick();
        apply();
        #1;
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        async_reset();
        log_d.delete();
        log_id.delete();
        out_ready = 1'b1;
        req_v[1] = 1'b1; req_d[1] = 11;
        req_v[3] = 1'b1; req_d[3] = 33;
        apply();
        #1;
        chk("post_reset_grant", 32'(in_ready), 32'b0010);
        chk("post_reset_no_stale", 32'(out_valid), 32'd0);
        for (int t = 0; t < 6; t++) tick();
        chk("post_reset_count", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            chk("post_reset_first_id", 32'(log_id[0]), 32'd1);
            chk("post_reset_second_id", 32'(log_id[1]), 32'd3);
        end

        // Randomized traffic with one mid-run asynchronous reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    req_d[i] = int'($urandom_range(0, 131071));
                end
            end
            if (c == 1500) async_reset();
            tick();
        end
        for (int i = 0; i < N; i++) req_v[i] = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/barret_367_arbiter.md
BARRET_367_ARBITER -- requirements
Module: barret_367_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the reducer.
REQ-002 Parameter ID_W, default 2: requester-index width, equal to clog2(NUM_REQ).
REQ-003 The clock port SHALL be `clk  input  1  rising-edge clock`.
REQ-004 The reset port SHALL be `rst  input  1  asynchronous, active-high reset`.
REQ-005 The request-valid port SHALL be `in_valid  input  NUM_REQ  per-requester operand valid`.
REQ-006 The operand port SHALL be `in_data  input  NUM_REQ*17  per-requester operand; requester i occupies bits [17*i+16:17*i]`.
REQ-007 The request-ready port SHALL be `in_ready  output  NUM_REQ  per-requester accept; one-hot or zero`.
REQ-008 The result-valid port SHALL be `out_valid  output  1  result valid`.
REQ-009 The result-ready port SHALL be `out_ready  input  1  downstream accept`.
REQ-010 The result-data port SHALL be `out_data  output  9  operand mod 367`.
REQ-011 The result-ID port SHALL be `out_id  output  ID_W  index of the requester that supplied the operand`.

Function
REQ-012 A transfer from requester i SHALL occur on a rising edge where in_valid[i] and in_ready[i] are both high; a result transfer SHALL occur where out_valid and out_ready are both high.
REQ-013 The block SHALL form a two-stage pipeline:
- S1 holds the operand, ID and valid bit.
- S2 holds the reduced result, ID and valid bit.
- out_valid, out_data and out_id are driven directly from S2.
REQ-014 The advance signal SHALL be adv = !s2_valid | out_ready; S1 moves into S2 on an edge where adv is high, and S2 clears when adv is high and S1 is empty.
REQ-015 S1 SHALL accept a new operand on an edge where !s1_valid | adv is high; that condition is named accept_ok.
REQ-016 The grant SHALL be combinational round-robin:
- The search starts at pointer rr_ptr and wraps from NUM_REQ-1 to 0.
- The first index with in_valid set is granted.
- in_ready[i] = grant[i] & accept_ok.
REQ-017 rr_ptr SHALL update to (granted index + 1) mod NUM_REQ only on an accepted transfer; it SHALL hold when no request is present or accept_ok is low.
REQ-018 in_ready SHALL not depend combinationally on in_data.
REQ-019 in_ready[i] MAY depend on in_valid, but a requester SHALL hold in_valid and in_data stable until accepted; the block does not check this.
REQ-020 Latency SHALL be as follows:
- An operand accepted at edge E appears on out_data with out_valid high after edge E+1 when out_ready was high.
- Throughput is one result per cycle.
REQ-021 out_data SHALL equal operand mod 367 for every 17-bit operand 0..131071.
REQ-022 While out_valid is high and out_ready is low, out_data and out_id SHALL be held stable.
REQ-023 Under a sustained stall with both stages full, every in_ready SHALL be low.
REQ-024 Results SHALL leave in acceptance order; no result is dropped or duplicated.
REQ-025 When all requesters assert in_valid continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester waiting more than NUM_REQ accepted transfers.

Reset
REQ-026 Asserting rst at any time SHALL asynchronously clear s1_valid, s2_valid, out_data, out_id and rr_ptr to 0, including mid-pipeline.
REQ-027 In-flight operands SHALL be discarded and no result SHALL be emitted for them.
REQ-028 in_ready SHALL be low while rst is high.
REQ-029 The first accepted transfer after reset SHALL be the lowest-index valid requester.

Structure
REQ-030 Package barret_367_pkg SHALL hold:
- Q = 367.
- IN_W = 17 and OUT_W = 9.
- Default NUM_REQ and ID_W.
REQ-031 The reduction SHALL be performed by one instance of the existing combinational sub-module barret_for_367 (din_a from S1 operand, dout_r into S2).
REQ-032 No other arithmetic SHALL perform the reduction.
REQ-033 Arbitration and pointer logic SHALL remain inside barret_367_arbiter.

Verification
REQ-034 Single request: in_valid=4'b0100, operand 1000, out_ready=1 → in_ready[2] high that cycle; two edges later out_valid=1, out_data=266, out_id=2.
REQ-035 Boundary operands from requester 0 → expected results:
- 0 → 0
- 366 → 366
- 367 → 0
- 131071 → 52
- 134 → 134
- All 367..1100 match i mod 367.
REQ-036 Fairness: from reset all four requesters valid continuously with operands 10,20,30,40 and out_ready=1 → out_id sequence 0,1,2,3,0,1 and out_data 10,20,30,40,10,20.
REQ-037 Backpressure: issue 5 requests, then hold out_ready=0 for 4 cycles.
- After 2 accepts, in_ready goes all low.
- out_data and out_id stay frozen while stalled.
- On release, the remaining results arrive in order with none lost.
REQ-038 Reset mid-op: assert rst for 1 cycle while both stages are valid → out_valid=0 immediately (asynchronously) and rr_ptr=0.
REQ-039 After the reset in REQ-038, requesters 1 and 3 valid → first grant goes to 1 and no stale result appears.
